// File: rtl/sdram_types_pkg.sv
// Shared SDRAM types: command words, command enum, scheduler state and request records.
// The scheduler uses these with or without SDRAM_OPEN_PAGE_EN.
package sdram_types_pkg;

    localparam int BA_W  = 2;
    localparam int ROW_W = 13;
    localparam int COL_W = 9;
    localparam int DQ_W  = 16;

    localparam logic [3:0] DEBT_MAX = 4'd8;

    typedef enum logic [2:0] {
        CMD_NOP,
        CMD_ACT,
        CMD_PRE,
        CMD_READ,
        CMD_WRITE,
        CMD_PALL,
        CMD_REF,
        CMD_MRS
    } cmd_t;

    typedef struct packed {
        logic [COL_W-1:0] column;
        logic [DQ_W-1:0]  data;
    } cmd_data_t;

    typedef struct packed {
        cmd_t            cmd;
        logic [BA_W-1:0] ba;
        cmd_data_t       d;
    } data_t;

    typedef enum logic [3:0] {
        S_WAIT,
        S_IPALL,
        S_IREF,
        S_IMRS,
        S_IDLE,
        S_RPALL,
        S_RREF,
        S_PRE,
        S_ACT,
        S_RD,
        S_WR
    } sched_state_t;

    typedef struct packed {
        logic             write;
        logic [1:0]       id;
        logic [BA_W-1:0]  ba;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } sched_req_t;

    function automatic data_t mk_cmd(cmd_t c, logic [BA_W-1:0] ba,
                                     logic [COL_W-1:0] col, logic [DQ_W-1:0] dat);
        data_t w;
        w.cmd      = c;
        w.ba       = ba;
        w.d.column = col;
        w.d.data   = dat;
        return w;
    endfunction

endpackage

// File: rtl/sdram_bank_track.sv
// Per-bank open-row table for the open-page policy (used only with SDRAM_OPEN_PAGE_EN).
module sdram_bank_track
    import sdram_types_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr_all,
    input  logic             i_set,
    input  logic [BA_W-1:0]  i_set_ba,
    input  logic [ROW_W-1:0] i_set_row,
    input  logic             i_clr,
    input  logic [BA_W-1:0]  i_clr_ba,
    input  logic [BA_W-1:0]  i_q_ba,
    input  logic [ROW_W-1:0] i_q_row,
    output logic             o_open,
    output logic             o_hit
);

    logic [3:0]       r_open;
    logic [ROW_W-1:0] r_row [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_open <= '0;
        end else if (i_clr_all) begin
            r_open <= '0;
        end else begin
            if (i_clr) r_open[i_clr_ba] <= 1'b0;
            if (i_set) r_open[i_set_ba] <= 1'b1;
        end
    end

    // Row contents are only meaningful while the open bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        if (i_set) r_row[i_set_ba] <= i_set_row;
    end

    assign o_open = r_open[i_q_ba];
    assign o_hit  = o_open && (r_row[i_q_ba] == i_q_row);

endmodule

// File: rtl/sdram_sched.sv
// SDRAM command scheduler: power-up sequence, refresh debt and burst access ordering.
// SDRAM_OPEN_PAGE_EN selects open-page with row tracking; otherwise closed-page.
module sdram_sched
    import sdram_types_pkg::*;
#(
    parameter int BURST    = 8,
    parameter int INIT_REF = 2
) (
    input  logic             clkSDRAM,
    input  logic             n_reset,
    input  logic             icnt_ovf,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_id,
    input  logic [BA_W-1:0]  req_ba,
    input  logic [ROW_W-1:0] req_row,
    input  logic [COL_W-1:0] req_col,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [DQ_W-1:0]  wr_data,
    input  logic             full,
    output logic             fifo_wrreq,
    output data_t            fifo_in,
    output logic             init_done
);

    localparam int BW = $clog2(BURST);
    localparam int IW = (INIT_REF > 1) ? $clog2(INIT_REF) : 1;

    sched_state_t  r_state;
    sched_state_t  w_next;
    logic          r_init_done;
    logic [3:0]    r_debt;
    logic [BW-1:0] r_cnt;
    logic [IW-1:0] r_iref;
    sched_req_t    r_req;
    logic          w_accept;
    logic          w_inc;
    logic          w_dec;
    logic          w_last_wr;
    sched_state_t  w_first;
    sched_state_t  w_after;
    sched_state_t  w_pre_next;

    assign req_ready = (r_state == S_IDLE) && r_init_done && (r_debt == 4'd0);
    assign w_accept  = req_valid && req_ready;
    assign init_done = r_init_done;
    assign w_inc     = icnt_ovf && r_init_done;
    assign w_dec     = (r_state == S_RREF) && fifo_wrreq;
    assign w_last_wr = (r_cnt == BW'(BURST - 1));

`ifdef SDRAM_OPEN_PAGE_EN
    logic w_open;
    logic w_hit;

    sdram_bank_track u_bank (
        .clk       (clkSDRAM),
        .rst_n     (n_reset),
        .i_clr_all (((r_state == S_RPALL) || (r_state == S_IPALL)) && fifo_wrreq),
        .i_set     ((r_state == S_ACT) && fifo_wrreq),
        .i_set_ba  (r_req.ba),
        .i_set_row (r_req.row),
        .i_clr     ((r_state == S_PRE) && fifo_wrreq),
        .i_clr_ba  (r_req.ba),
        .i_q_ba    (req_ba),
        .i_q_row   (req_row),
        .o_open    (w_open),
        .o_hit     (w_hit)
    );

    assign w_first    = w_hit ? (req_write ? S_WR : S_RD) : (w_open ? S_PRE : S_ACT);
    assign w_after    = S_IDLE;
    assign w_pre_next = S_ACT;
`else
    // Closed page: every access opens its row and precharges it afterwards.
    assign w_first    = S_ACT;
    assign w_after    = S_PRE;
    assign w_pre_next = S_IDLE;
`endif

    always_ff @(posedge clkSDRAM or negedge n_reset) begin
        if (!n_reset) begin
            r_state     <= S_WAIT;
            r_init_done <= 1'b0;
            r_debt      <= 4'd0;
            r_cnt       <= '0;
            r_iref      <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IMRS) && fifo_wrreq) r_init_done <= 1'b1;
            if (w_inc && !w_dec && (r_debt != DEBT_MAX)) r_debt <= r_debt + 4'd1;
            else if (w_dec && !w_inc) r_debt <= r_debt - 4'd1;
            if ((r_state == S_WR) && fifo_wrreq) r_cnt <= r_cnt + 1'b1;
            if ((r_state == S_IREF) && fifo_wrreq)
                r_iref <= (r_iref == IW'(INIT_REF - 1)) ? '0 : r_iref + 1'b1;
        end
    end

    always_ff @(posedge clkSDRAM) begin
        if (w_accept)
            r_req <= '{write: req_write, id: req_id, ba: req_ba, row: req_row,
                       col: req_col & ~COL_W'(BURST - 1)};
    end

    // Command states hold their word on the bus until the FIFO takes it.
    always_comb begin
        w_next     = r_state;
        fifo_wrreq = 1'b0;
        wr_ready   = 1'b0;
        fifo_in    = mk_cmd(CMD_NOP, '0, '0, '0);
        case (r_state)
            S_WAIT: begin
                if (icnt_ovf) w_next = S_IPALL;
            end
            S_IPALL: begin
                fifo_in    = mk_cmd(CMD_PALL, '0, '0, '0);
                fifo_wrreq = !full;
                if (!full) w_next = S_IREF;
            end
            S_IREF: begin
                fifo_in    = mk_cmd(CMD_REF, '0, '0, '0);
                fifo_wrreq = !full;
                if (!full && (r_iref == IW'(INIT_REF - 1))) w_next = S_IMRS;
            end
            S_IMRS: begin
                fifo_in    = mk_cmd(CMD_MRS, '0, '0, '0);
                fifo_wrreq = !full;
                if (!full) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (r_debt != 4'd0) w_next = S_RPALL;
                else if (w_accept) w_next = w_first;
            end
            S_RPALL: begin
                fifo_in    = mk_cmd(CMD_PALL, '0, '0, '0);
                fifo_wrreq = !full;
                if (!full) w_next = S_RREF;
            end
            S_RREF: begin
                fifo_in    = mk_cmd(CMD_REF, '0, '0, '0);
                fifo_wrreq = !full;
                if (!full) w_next = S_IDLE;
            end
            S_PRE: begin
                fifo_in    = mk_cmd(CMD_PRE, r_req.ba, '0, '0);
                fifo_wrreq = !full;
                if (!full) w_next = w_pre_next;
            end
            S_ACT: begin
                fifo_in    = mk_cmd(CMD_ACT, r_req.ba, '0, DQ_W'(r_req.row));
                fifo_wrreq = !full;
                if (!full) w_next = r_req.write ? S_WR : S_RD;
            end
            S_RD: begin
                fifo_in    = mk_cmd(CMD_READ, r_req.ba, r_req.col, DQ_W'(r_req.id));
                fifo_wrreq = !full;
                if (!full) w_next = w_after;
            end
            S_WR: begin
                fifo_in    = mk_cmd(CMD_WRITE, r_req.ba, r_req.col | COL_W'(r_cnt), wr_data);
                fifo_wrreq = !full && wr_valid;
                wr_ready   = fifo_wrreq;
                if (fifo_wrreq && w_last_wr) w_next = w_after;
            end
            default: begin
                w_next = S_WAIT;
            end
        endcase
    end

endmodule

// File: tb/tb_sdram_sched.sv
// Self-checking bench for sdram_sched: randomized traffic against a queue-based command model.
`timescale 1ns/1ps
module tb_sdram_sched;
    import sdram_types_pkg::*;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        icnt_ovf = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_id = '0;
    logic [1:0]  req_ba = '0;
    logic [12:0] req_row = '0;
    logic [8:0]  req_col = '0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = '0;
    logic        full = 1'b0;
    logic        req_ready, wr_ready, fifo_wrreq, init_done;
    data_t       fifo_in;

    sdram_sched #(.BURST(8), .INIT_REF(2)) dut (
        .clkSDRAM(clk), .n_reset(n_reset), .icnt_ovf(icnt_ovf),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .full(full), .fifo_wrreq(fifo_wrreq), .fifo_in(fifo_in), .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Model: expected FIFO word stream, pending refresh pairs, pending write words.
    data_t       exp_q[$];
    logic [15:0] wq[$];
    int          m_debt = 0;
    bit          m_init = 0;
    bit          m_waited = 0;
`ifdef SDRAM_OPEN_PAGE_EN
    bit          m_bopen[4];
    logic [12:0] m_brow[4];
`endif
    data_t       log_w[$];
    int          log_c[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_err = 0;
    bit          rand_mode = 0, toggle_mode = 0, force_full = 0, force_ovf = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic m_clear_banks();
`ifdef SDRAM_OPEN_PAGE_EN
        for (int i = 0; i < 4; i++) m_bopen[i] = 0;
`endif
    endtask

    task automatic m_accept();
        logic [8:0] base;
        logic [15:0] w;
        base = {req_col[8:3], 3'b000};
`ifdef SDRAM_OPEN_PAGE_EN
        if (!(m_bopen[req_ba] && m_brow[req_ba] == req_row)) begin
            if (m_bopen[req_ba]) exp_q.push_back(mk_cmd(CMD_PRE, req_ba, 9'd0, 16'd0));
            exp_q.push_back(mk_cmd(CMD_ACT, req_ba, 9'd0, {3'b000, req_row}));
            m_bopen[req_ba] = 1;
            m_brow[req_ba]  = req_row;
        end
`else
        exp_q.push_back(mk_cmd(CMD_ACT, req_ba, 9'd0, {3'b000, req_row}));
`endif
        if (req_write) begin
            for (int i = 0; i < 8; i++) begin
                w = 16'($urandom);
                wq.push_back(w);
                exp_q.push_back(mk_cmd(CMD_WRITE, req_ba, base + 9'(i), w));
            end
        end else begin
            exp_q.push_back(mk_cmd(CMD_READ, req_ba, base, {14'd0, req_id}));
        end
`ifndef SDRAM_OPEN_PAGE_EN
        exp_q.push_back(mk_cmd(CMD_PRE, req_ba, 9'd0, 16'd0));
`endif
    endtask

    // Compare process: every cycle, outputs are held up against the model.
    always @(negedge clk) begin
        data_t e;
        bit    init_prev;
        if (!n_reset) begin
            exp_q.delete(); wq.delete();
            m_debt = 0; m_init = 0; m_waited = 0;
            m_clear_banks();
        end else begin
            init_prev = m_init;
            chk("req_ready", req_ready, m_init && exp_q.size() == 0 && m_debt == 0);
            chk("init_done", init_done, m_init);
            if (full) chk("wrreq_while_full", fifo_wrreq, 0);
            chk("wr_ready", wr_ready,
                fifo_wrreq && exp_q.size() > 0 && exp_q[0].cmd == CMD_WRITE);
            if (fifo_wrreq) begin
                log_w.push_back(fifo_in);
                log_c.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL unexpected_cmd: got %h, expected no FIFO write (cycle %0d)", fifo_in, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("fifo_in", fifo_in, e);
                    if (e.cmd == CMD_MRS) m_init = 1;
                    if (e.cmd == CMD_REF && init_prev) m_debt--;
                end
            end
            if (wr_valid && wr_ready && wq.size() > 0) void'(wq.pop_front());
            if (req_valid && req_ready) m_accept();
            if (icnt_ovf) begin
                if (!init_prev) begin
                    if (!m_waited) begin
                        m_waited = 1;
                        exp_q.push_back(mk_cmd(CMD_PALL, 2'd0, 9'd0, 16'd0));
                        exp_q.push_back(mk_cmd(CMD_REF, 2'd0, 9'd0, 16'd0));
                        exp_q.push_back(mk_cmd(CMD_REF, 2'd0, 9'd0, 16'd0));
                        exp_q.push_back(mk_cmd(CMD_MRS, 2'd0, 9'd0, 16'd0));
                    end
                end else if (m_debt < 8) begin
                    m_debt++;
                    exp_q.push_back(mk_cmd(CMD_PALL, 2'd0, 9'd0, 16'd0));
                    exp_q.push_back(mk_cmd(CMD_REF, 2'd0, 9'd0, 16'd0));
                    m_clear_banks();
                end
            end
        end
    end

    // Background input driver.
    initial forever begin
        @(posedge clk); #2;
        if (rand_mode) begin
            full     = ($urandom_range(0, 3) == 0);
            wr_valid = ($urandom_range(0, 2) != 0);
            icnt_ovf = ($urandom_range(0, 59) == 0);
        end else begin
            full     = force_full;
            wr_valid = toggle_mode ? ~wr_valid : 1'b1;
            icnt_ovf = force_ovf;
        end
        wr_data = (wq.size() > 0) ? wq[0] : 16'hDEAD;
    end

    task automatic pulse_ovf();
        @(posedge clk); #1 force_ovf = 1;
        @(posedge clk); #1 force_ovf = 0;
    endtask

    task automatic drain(int lim);
        int k = 0;
        while (exp_q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("drain_pending", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input bit w, input logic [1:0] id, input logic [1:0] ba,
                          input logic [12:0] row, input logic [8:0] col, output int hs);
        int k = 0;
        bit got = 0;
        hs = 0;
        @(posedge clk); #1;
        req_valid = 1; req_write = w; req_id = id; req_ba = ba; req_row = row; req_col = col;
        while (!got && k < 3000) begin
            @(negedge clk);
            if (req_ready) begin
                got = 1;
                hs  = cyc;
            end
            k++;
        end
        chk("req_accepted", got, 1);
        @(posedge clk); #1 req_valid = 0;
    endtask

    task automatic chk_log(string nm, int idx, data_t w, int c);
        if (idx < log_w.size()) begin
            chk({nm, "_word"}, log_w[idx], w);
            chk({nm, "_cycle"}, log_c[idx], c);
        end else begin
            chk({nm, "_missing"}, log_w.size(), idx + 1);
        end
    endtask

    task automatic chk_init(int lb);
        if (lb + 3 < log_w.size()) begin
            chk("init_pall", log_w[lb].cmd, CMD_PALL);
            chk("init_ref0", log_w[lb + 1].cmd, CMD_REF);
            chk("init_ref1", log_w[lb + 2].cmd, CMD_REF);
            chk("init_mrs", log_w[lb + 3].cmd, CMD_MRS);
            chk("init_span", log_c[lb + 3] - log_c[lb], 3);
        end else begin
            chk("init_missing", log_w.size(), lb + 4);
        end
        chk("init_done_lit", init_done, 1);
    endtask

    initial begin
        int hs, lb, np, nr, nw, k;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_fifo_wrreq", fifo_wrreq, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_fifo_in", fifo_in, 30'h0);
        n_reset = 1;
        repeat (5) @(posedge clk);

        lb = log_w.size();
        pulse_ovf();
        drain(50);
        chk_init(lb);

        lb = log_w.size();
        do_req(0, 2'd2, 2'd1, 13'h123, 9'h48, hs);
        drain(50);
        chk_log("rd1_act", lb, mk_cmd(CMD_ACT, 2'd1, 9'd0, 16'h0123), hs + 1);
        chk_log("rd1_read", lb + 1, mk_cmd(CMD_READ, 2'd1, 9'h048, 16'd2), hs + 2);

        lb = log_w.size();
        do_req(0, 2'd1, 2'd1, 13'h123, 9'h48, hs);
        drain(50);
`ifdef SDRAM_OPEN_PAGE_EN
        chk_log("rd2_hit_read", lb, mk_cmd(CMD_READ, 2'd1, 9'h048, 16'd1), hs + 1);
`else
        chk_log("rd2_act", lb, mk_cmd(CMD_ACT, 2'd1, 9'd0, 16'h0123), hs + 1);
        chk_log("rd2_read", lb + 1, mk_cmd(CMD_READ, 2'd1, 9'h048, 16'd1), hs + 2);
`endif

        lb = log_w.size();
        do_req(0, 2'd3, 2'd1, 13'h124, 9'h4F, hs);
        drain(50);
`ifdef SDRAM_OPEN_PAGE_EN
        chk_log("rd3_pre", lb, mk_cmd(CMD_PRE, 2'd1, 9'd0, 16'd0), hs + 1);
        chk_log("rd3_act", lb + 1, mk_cmd(CMD_ACT, 2'd1, 9'd0, 16'h0124), hs + 2);
        chk_log("rd3_read", lb + 2, mk_cmd(CMD_READ, 2'd1, 9'h048, 16'd3), hs + 3);
`else
        chk_log("rd3_act", lb, mk_cmd(CMD_ACT, 2'd1, 9'd0, 16'h0124), hs + 1);
        chk_log("rd3_read", lb + 1, mk_cmd(CMD_READ, 2'd1, 9'h048, 16'd3), hs + 2);
        chk_log("rd3_pre", lb + 2, mk_cmd(CMD_PRE, 2'd1, 9'd0, 16'd0), hs + 3);
`endif

        // Write burst with wr_valid toggling and a 3-cycle full window mid-burst.
        toggle_mode = 1;
        lb = log_w.size();
        do_req(1, 2'd0, 2'd2, 13'h055, 9'h13, hs);
        repeat (3) @(posedge clk);
        #1 force_full = 1;
        repeat (3) @(posedge clk);
        #1 force_full = 0;
        drain(100);
        toggle_mode = 0;
        nw = 0;
        for (int i = lb; i < log_w.size(); i++) begin
            if (log_w[i].cmd == CMD_WRITE) begin
                chk("wr_column", log_w[i].d.column, 9'h010 + 9'(nw));
                nw++;
            end
        end
        chk("wr_count", nw, 8);

        // Nine refresh ticks while the FIFO is full: debt saturates at eight.
        @(posedge clk); #1 force_full = 1;
        lb = log_w.size();
        for (int i = 0; i < 9; i++) pulse_ovf();
        @(negedge clk);
        chk("sat_ready_low", req_ready, 0);
        @(posedge clk); #1 force_full = 0;
        drain(200);
        np = 0; nr = 0;
        for (int i = lb; i < log_w.size(); i++) begin
            if (log_w[i].cmd == CMD_PALL) np++;
            if (log_w[i].cmd == CMD_REF) nr++;
        end
        chk("sat_pall_count", np, 8);
        chk("sat_ref_count", nr, 8);
        chk("sat_ready_high", req_ready, 1);

        // Randomized traffic with random backpressure and refresh ticks.
        rand_mode = 1;
        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_req(1'($urandom), 2'($urandom), 2'($urandom), 13'($urandom_range(0, 2)),
                   9'($urandom), hs);
        end
        rand_mode = 0;
        drain(1000);

        // Reset in the middle of a write burst.
        do_req(1, 2'd0, 2'd3, 13'h0AA, 9'h20, hs);
        k = 0; nw = 0;
        while (nw < 3 && k < 100) begin
            @(negedge clk);
            if (fifo_wrreq && fifo_in.cmd == CMD_WRITE) nw++;
            k++;
        end
        chk("midwr_reached", nw, 3);
        @(posedge clk); #1 n_reset = 0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        chk("mid_rst_wr_ready", wr_ready, 0);
        chk("mid_rst_fifo_wrreq", fifo_wrreq, 0);
        chk("mid_rst_init_done", init_done, 0);
        chk("mid_rst_fifo_in", fifo_in, 30'h0);
        repeat (2) @(posedge clk);
        #1 n_reset = 1;
        repeat (6) @(posedge clk);
        lb = log_w.size();
        chk("restart_wait_idle", lb, log_w.size());
        pulse_ovf();
        drain(50);
        chk_init(lb);
        lb = log_w.size();
        do_req(0, 2'd0, 2'd1, 13'h124, 9'h48, hs);
        drain(50);
        chk_log("post_rst_act", lb, mk_cmd(CMD_ACT, 2'd1, 9'd0, 16'h0124), hs + 1);

        chk("final_queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sdram_sched.md
# sdram_sched

Command scheduler that turns burst read/write requests from the capture and display logic into the per-cycle SDRAM command stream consumed by `sdram_io` through the shared command FIFO. Runs the power-up sequence (PALL, CBR refreshes, MRS), schedules auto-refresh on `icnt_ovf`, tracks open rows, and emits ACT/PRE/READ/WRITE entries as `data_t` words. All SDRAM timing constraints are enforced downstream by `sdram_io`; this block only orders commands and respects FIFO backpressure.

## Interface
- `BURST`, 8: words per request; must be a power of two.
- `INIT_REF`, 2: CBR refreshes issued during initialisation.
- `clkSDRAM`  in  1  SDRAM clock.
- `n_reset`  in  1  reset, asynchronous, active-low.
- `icnt_ovf`  in  1  one-cycle tick from `sdram_io`: first pulse is end of tINIT, later pulses are refresh requests.
- `req_valid` / `req_ready`  in / out  1  request handshake; transfer when both are high.
- `req_write`  in  1  1 = write burst, 0 = read burst.
- `req_id`  in  2  read tag, returned by `sdram_io` as `data_id_io`.
- `req_ba`, `req_row`, `req_col`  in  2, 13, 9  address; `req_col` low log2(`BURST`) bits forced to 0.
- `wr_valid` / `wr_ready`  in / out  1  write-data handshake.
- `wr_data`  in  16  write word.
- `full`  in  1  command FIFO full.
- `fifo_wrreq`  out  1  FIFO write strobe.
- `fifo_in`  out  `data_t`  command word.
- `init_done`  out  1  high once MRS has been written.

## Operation
- States: WAIT, IPALL, IREF, IMRS, IDLE, RPALL, RREF, PRE, ACT, RD, WR.
- Command states hold until written: `fifo_wrreq` = command state && ~`full`. In WR it also requires `wr_valid`, and `wr_ready` = `fifo_wrreq` in WR.
- Init: WAIT until the first `icnt_ovf` (not counted as refresh debt), then IPALL → IREF ×`INIT_REF` → IMRS → IDLE, setting `init_done`.
- Refresh debt: 4-bit counter, +1 per `icnt_ovf` after init, saturates at 8, −1 per REF written. Simultaneous increment and decrement leaves it unchanged.
- In IDLE with debt ≠ 0: RPALL → RREF. All banks are marked closed at PALL.
- `req_ready` = IDLE && `init_done` && debt == 0 (registered debt). A request accepted in the same cycle as `icnt_ovf` is served first.
- Request path: bank open on same row → RD/WR. Bank open on a different row → PRE → ACT → RD/WR. Bank closed → ACT → RD/WR. ACT marks {bank, row} open.
- Field encoding:
  - ACT: `d.data[12:0]` = row.
  - RD: one READ, `d.column` = col base, `d.data[1:0]` = `req_id`.
  - WR: `BURST` WRITE entries, columns base..base+`BURST`−1, `d.data` = `wr_data`; column offset counter wraps at `BURST`.
  - PALL/REF/MRS: `ba` and `d` are 0.
- Back to IDLE after the last RD/WR entry is written.

## Timing
- Reset values:
  - `req_ready` = 0, `wr_ready` = 0, `fifo_wrreq` = 0, `init_done` = 0.
  - `fifo_in` = {NOP, 0, 0}.
  - Debt = 0, all banks closed, state WAIT.
- `fifo_wrreq`, `fifo_in` and `wr_ready` are combinational from registered state plus `full` / `wr_valid` / `wr_data`. State advances on the clock edge where `fifo_wrreq` = 1.
- Request handshake cycle 0 with FIFO not full:
  - Row hit: READ written at cycle 1.
  - Closed bank: ACT at cycle 1, READ at cycle 2.
  - Row miss: PRE at 1, ACT at 2, READ at 3.
- `full` stalls every state without loss or duplication. `wr_valid` low in WR inserts bubbles.
- `n_reset` asserted mid-burst: immediate return to reset state. The FIFO shares the reset.

## Configuration
- `SDRAM_OPEN_PAGE_EN` defined: open-page policy as above, with per-bank row tracking.
- Undefined: closed-page policy. Every request is ACT → RD/WR → PRE, with no row tracking and banks always closed in IDLE.

## Structure
- `sdram_types` gains the state enum `sched_state_t` and a request struct `sched_req_t` {write, id, ba, row, col}. It reuses the existing `data_t` and command enum.
- Sub-module `sdram_bank_track` holds 4 × {open, row[12:0]}, with hit/open outputs, a clear-all input and per-bank set/clear. It is instantiated only under `SDRAM_OPEN_PAGE_EN`.

## Test plan
- Reset, then `icnt_ovf` pulse, with `full` = 0 → FIFO receives PALL, REF, REF, MRS on 4 consecutive cycles, then `init_done` = 1.
- Read ba=1 row=0x123 col=0x48, id=2 → ACT(ba 1, data 0x123), then READ(col 0x48, data[1:0]=2) on the next cycle.
- Open page: second read to ba=1 row=0x123 → READ only. Then a read to row 0x124 → PRE, ACT, READ.
- Write burst with `wr_valid` toggling and `full` high for 3 cycles mid-burst → exactly 8 WRITEs, columns base..base+7, data in order, none duplicated.
- Nine `icnt_ovf` pulses with `req_valid` held low → 8 RPALL/REF pairs (saturation), `req_ready` low until debt reaches 0.
- `n_reset` pulsed during WR state → outputs return to reset values, and the next sequence restarts at WAIT.
